// File: rtl/hazard_scoreboard_unit_pkg.sv
`default_nettype none
// ============================================================================
// hazard_pkg : shared constants and ready-count helper for the scoreboard
// Revision   : 1.0
// ============================================================================
package hazard_pkg;

  localparam int REG_AW    = 5;
  localparam int ALU_READY = 1;

  // Countdown loaded at issue: ALU results forward after EX, loads LOAD_LAT later.
  function automatic int ready_val(input logic is_load, input int load_lat);
    return is_load ? load_lat + 1 : ALU_READY;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_sb_entry.sv
`default_nettype none
// ============================================================================
// hazard_sb_entry : one register's readiness countdown (load / decrement / freeze)
// Revision        : 1.0
// ============================================================================
module hazard_sb_entry
  import hazard_pkg::*;
#(
  parameter int CW = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          freeze_i,
  output logic [CW-1:0] cnt_o,
  output logic          nz_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!freeze_i) begin
      if (load_i)
        cnt_d = load_val_i;
      else if (cnt_q != '0)
        cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign nz_o  = (cnt_q != '0);

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard_unit.sv
`default_nettype none
// ============================================================================
// hazard_scoreboard_unit : per-register countdown scoreboard driving ID stalls/flushes
// Revision               : 1.0
// ============================================================================
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int AW       = REG_AW,
  parameter int LOAD_LAT = 1,
  parameter int CW       = 3,
  parameter int SCW      = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            ID_valid_i,
  input  logic [AW-1:0]   RS1addr_i,
  input  logic [AW-1:0]   RS2addr_i,
  input  logic            RS1use_i,
  input  logic            RS2use_i,
  input  logic            Branch_i,
  input  logic            Jal_i,
  input  logic            Jalr_i,
  input  logic            Predict_wrong_i,
  input  logic            RegWrite_i,
  input  logic            MemRead_i,
  input  logic [AW-1:0]   RDaddr_i,
  input  logic            Mem_busy_i,
  output logic            Stall_o,
  output logic            Flush_IFID_o,
  output logic            Flush_IDEX_o,
  output logic [NREG-1:0] Pending_o,
  output logic [SCW-1:0]  Stall_cnt_o
);

  localparam int            NSLOT    = 1 << AW;
  localparam logic [CW-1:0] LOAD_CNT = CW'(ready_val(1'b1, LOAD_LAT));
  localparam logic [CW-1:0] ALU_CNT  = CW'(ready_val(1'b0, LOAD_LAT));

  logic [CW-1:0]    cnt [NSLOT];
  logic [NSLOT-1:0] nz;
  logic [CW-1:0]    cnt1, cnt2, load_val;
  logic             rs1_v, rs2_v, ex_haz, id_haz, haz, issue, wr_en;
  logic [SCW-1:0]   stall_cnt_q, stall_cnt_d;

  assign rs1_v = ID_valid_i & RS1use_i & (RS1addr_i != '0);
  assign rs2_v = ID_valid_i & RS2use_i & (RS2addr_i != '0);
  assign cnt1  = cnt[RS1addr_i];
  assign cnt2  = cnt[RS2addr_i];

  // EX consumers wait until the value is forwardable; ID consumers wait for zero.
  assign ex_haz = (rs1_v & (cnt1 > ALU_CNT)) | (rs2_v & (cnt2 > ALU_CNT));
  assign id_haz = (rs1_v & (Branch_i | Jalr_i) & (cnt1 != '0))
                | (rs2_v & Branch_i & (cnt2 != '0));
  assign haz    = ex_haz | id_haz;

  assign issue        = ID_valid_i & ~haz & ~Mem_busy_i;
  assign wr_en        = issue & RegWrite_i;
  assign load_val     = MemRead_i ? LOAD_CNT : ALU_CNT;
  assign Stall_o      = haz | Mem_busy_i;
  assign Flush_IDEX_o = haz & ~Mem_busy_i;
  assign Flush_IFID_o = issue & (Jal_i | Jalr_i | Predict_wrong_i);

  // Slots for x0 and unimplemented addresses read as permanently ready.
  for (genvar r = 0; r < NSLOT; r++) begin : g_slot
    if (r > 0 && r < NREG) begin : g_entry
      hazard_sb_entry #(.CW(CW)) u_entry (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (wr_en & (RDaddr_i == AW'(r))),
        .load_val_i (load_val),
        .freeze_i   (Mem_busy_i),
        .cnt_o      (cnt[r]),
        .nz_o       (nz[r])
      );
    end else begin : g_zero
      assign cnt[r] = '0;
      assign nz[r]  = 1'b0;
    end
  end

  assign Pending_o = nz[NREG-1:0];

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (Flush_IDEX_o && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + SCW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign Stall_cnt_o = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard_unit.sv
`default_nettype none
// ============================================================================
// tb_hazard_scoreboard_unit : directed bench over three parameterisations
// Revision                  : 1.0
// ============================================================================
module tb_hazard_scoreboard_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid, rs1use, rs2use, branch, jal, jalr, pw, regwrite, memread, mem_busy;
  logic [4:0] rs1, rs2, rd;

  logic st1, fi1, fe1; logic [31:0] pend1; logic [15:0] sc1;
  logic st3, fi3, fe3; logic [31:0] pend3; logic [15:0] sc3;
  logic sts, fis, fes; logic [31:0] pends; logic [3:0]  scs;

  int n_cmp = 0;
  int n_fail = 0;
  int exp_sc;

  always #5 clk = ~clk;

  hazard_scoreboard_unit #(.LOAD_LAT(1)) dut1 (
    .clk_i(clk), .rst_i(rst_n), .ID_valid_i(id_valid), .RS1addr_i(rs1), .RS2addr_i(rs2),
    .RS1use_i(rs1use), .RS2use_i(rs2use), .Branch_i(branch), .Jal_i(jal), .Jalr_i(jalr),
    .Predict_wrong_i(pw), .RegWrite_i(regwrite), .MemRead_i(memread), .RDaddr_i(rd),
    .Mem_busy_i(mem_busy), .Stall_o(st1), .Flush_IFID_o(fi1), .Flush_IDEX_o(fe1),
    .Pending_o(pend1), .Stall_cnt_o(sc1));

  hazard_scoreboard_unit #(.LOAD_LAT(3)) dut3 (
    .clk_i(clk), .rst_i(rst_n), .ID_valid_i(id_valid), .RS1addr_i(rs1), .RS2addr_i(rs2),
    .RS1use_i(rs1use), .RS2use_i(rs2use), .Branch_i(branch), .Jal_i(jal), .Jalr_i(jalr),
    .Predict_wrong_i(pw), .RegWrite_i(regwrite), .MemRead_i(memread), .RDaddr_i(rd),
    .Mem_busy_i(mem_busy), .Stall_o(st3), .Flush_IFID_o(fi3), .Flush_IDEX_o(fe3),
    .Pending_o(pend3), .Stall_cnt_o(sc3));

  hazard_scoreboard_unit #(.LOAD_LAT(1), .SCW(4)) duts (
    .clk_i(clk), .rst_i(rst_n), .ID_valid_i(id_valid), .RS1addr_i(rs1), .RS2addr_i(rs2),
    .RS1use_i(rs1use), .RS2use_i(rs2use), .Branch_i(branch), .Jal_i(jal), .Jalr_i(jalr),
    .Predict_wrong_i(pw), .RegWrite_i(regwrite), .MemRead_i(memread), .RDaddr_i(rd),
    .Mem_busy_i(mem_busy), .Stall_o(sts), .Flush_IFID_o(fis), .Flush_IDEX_o(fes),
    .Pending_o(pends), .Stall_cnt_o(scs));

  task automatic set_instr(input logic v, input logic [4:0] a1, input logic u1,
                           input logic [4:0] a2, input logic u2, input logic [4:0] d,
                           input logic w, input logic ld, input logic br,
                           input logic jl, input logic jr, input logic p);
    id_valid = v; rs1 = a1; rs1use = u1; rs2 = a2; rs2use = u2; rd = d;
    regwrite = w; memread = ld; branch = br; jal = jl; jalr = jr; pw = p;
  endtask

  task automatic idle();
    set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mem_busy = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    #1;
    n_cmp++; if ({st1, fi1, fe1} !== 3'b000 || pend1 !== 32'h0 || sc1 !== 16'h0) begin
      n_fail++; $display("FAIL reset_initial: got flags=%b pend=%h cnt=%0d want 000/0/0", {st1, fi1, fe1}, pend1, sc1); end
    do_reset();
    set_instr(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0);       // lw x5
    tick();
    set_instr(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0);       // add x6,x5,x1
    tick();
    set_instr(1, 5, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0);       // beq x5,x0 at cnt=1
    @(negedge clk);
    n_cmp++; if (st1 !== 1'b1 || sc1 !== 16'd1 || pend1[5] !== 1'b1) begin
      n_fail++; $display("FAIL reset_prestall: got stall=%b cnt=%0d p5=%b want 1/1/1", st1, sc1, pend1[5]); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if ({st1, fi1, fe1} !== 3'b000 || pend1 !== 32'h0 || sc1 !== 16'h0) begin
      n_fail++; $display("FAIL reset_async: got flags=%b pend=%h cnt=%0d want 000/0/0", {st1, fi1, fe1}, pend1, sc1); end
    idle();
    tick();
    rst_n = 1'b1;
    set_instr(1, 5, 1, 6, 1, 7, 1, 0, 1, 0, 0, 0);
    @(negedge clk);
    n_cmp++; if ({st1, fi1, fe1} !== 3'b000 || pend1 !== 32'h0) begin
      n_fail++; $display("FAIL reset_release: got flags=%b pend=%h want 000/0", {st1, fi1, fe1}, pend1); end
    tick();
    idle();
  endtask

  task automatic test_load_use();
    do_reset();
    set_instr(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0);       // lw x5
    @(negedge clk);
    n_cmp++; if ({st1, fi1, fe1} !== 3'b000) begin
      n_fail++; $display("FAIL loaduse_issue: got %b want 000", {st1, fi1, fe1}); end
    tick();
    set_instr(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0);       // add x6,x5,x1
    @(negedge clk);
    n_cmp++; if ({st1, fi1, fe1} !== 3'b101) begin
      n_fail++; $display("FAIL loaduse_stall: got %b want 101", {st1, fi1, fe1}); end
    tick();
    @(negedge clk);
    n_cmp++; if ({st1, fi1, fe1} !== 3'b000) begin
      n_fail++; $display("FAIL loaduse_go: got %b want 000", {st1, fi1, fe1}); end
    tick();
    idle();
    @(negedge clk);
    n_cmp++; if (sc1 !== 16'd1 || pend1 !== 32'h0000_0040) begin
      n_fail++; $display("FAIL loaduse_after: got cnt=%0d pend=%h want 1/00000040", sc1, pend1); end
  endtask

  task automatic test_branch();
    do_reset();
    set_instr(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0);       // lw x5
    tick();
    set_instr(1, 5, 1, 0, 1, 0, 0, 0, 1, 0, 0, 1);       // beq x5,x0 mispredicted
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++; if ({st1, fi1, fe1} !== 3'b101) begin
        n_fail++; $display("FAIL branch_stall%0d: got %b want 101", i, {st1, fi1, fe1}); end
      tick();
    end
    @(negedge clk);
    n_cmp++; if ({st1, fi1, fe1} !== 3'b010) begin
      n_fail++; $display("FAIL branch_redirect: got %b want 010", {st1, fi1, fe1}); end
    tick();
    idle();
    @(negedge clk);
    n_cmp++; if (sc1 !== 16'd2 || pend1 !== 32'h0) begin
      n_fail++; $display("FAIL branch_after: got cnt=%0d pend=%h want 2/0", sc1, pend1); end
  endtask

  task automatic test_jalr_freeze();
    do_reset();
    set_instr(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0);       // lw x7
    tick();
    set_instr(1, 7, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0);       // jalr x0,0(x7)
    @(negedge clk);
    n_cmp++; if ({st3, fi3, fe3} !== 3'b101 || pend3[7] !== 1'b1) begin
      n_fail++; $display("FAIL jalr_first: got %b p7=%b want 101/1", {st3, fi3, fe3}, pend3[7]); end
    tick();
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if ({st3, fi3, fe3} !== 3'b100 || pend3[7] !== 1'b1 || sc3 !== 16'd1) begin
        n_fail++; $display("FAIL jalr_freeze%0d: got %b p7=%b cnt=%0d want 100/1/1", i, {st3, fi3, fe3}, pend3[7], sc3); end
      tick();
    end
    mem_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if ({st3, fi3, fe3} !== 3'b101) begin
        n_fail++; $display("FAIL jalr_stall%0d: got %b want 101", i, {st3, fi3, fe3}); end
      tick();
    end
    @(negedge clk);
    n_cmp++; if ({st3, fi3, fe3} !== 3'b010) begin
      n_fail++; $display("FAIL jalr_redirect: got %b want 010", {st3, fi3, fe3}); end
    tick();
    idle();
    @(negedge clk);
    n_cmp++; if (sc3 !== 16'd4 || pend3 !== 32'h0) begin
      n_fail++; $display("FAIL jalr_after: got cnt=%0d pend=%h want 4/0", sc3, pend3); end
  endtask

  task automatic test_x0_waw();
    do_reset();
    set_instr(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);       // lw x0
    tick();
    set_instr(1, 0, 1, 0, 1, 6, 1, 0, 0, 0, 0, 0);       // add x6,x0,x0
    @(negedge clk);
    n_cmp++; if ({st1, fi1, fe1} !== 3'b000 || pend1 !== 32'h0) begin
      n_fail++; $display("FAIL x0_use: got %b pend=%h want 000/0", {st1, fi1, fe1}, pend1); end
    tick();
    set_instr(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0);       // lw x9
    tick();
    idle();
    @(negedge clk);
    n_cmp++; if (pend1 !== 32'h0000_0200) begin
      n_fail++; $display("FAIL waw_pending: got %h want 00000200", pend1); end
    tick();
    set_instr(1, 9, 1, 0, 0, 9, 1, 0, 0, 0, 0, 0);       // addi x9,x9,1 at cnt=1
    @(negedge clk);
    n_cmp++; if ({st1, fi1, fe1} !== 3'b000) begin
      n_fail++; $display("FAIL waw_issue: got %b want 000", {st1, fi1, fe1}); end
    tick();
    set_instr(1, 9, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0);       // beq x9,x0
    @(negedge clk);
    n_cmp++; if ({st1, fi1, fe1} !== 3'b101 || pend1 !== 32'h0000_0200) begin
      n_fail++; $display("FAIL waw_branch_stall: got %b pend=%h want 101/00000200", {st1, fi1, fe1}, pend1); end
    tick();
    @(negedge clk);
    n_cmp++; if ({st1, fi1, fe1} !== 3'b000) begin
      n_fail++; $display("FAIL waw_branch_go: got %b want 000", {st1, fi1, fe1}); end
    tick();
    idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_instr(1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0);       // add x3,x1,x2
    tick();
    set_instr(1, 3, 1, 3, 1, 4, 1, 0, 0, 0, 0, 0);       // add x4,x3,x3
    @(negedge clk);
    n_cmp++; if ({st1, fi1, fe1} !== 3'b000) begin
      n_fail++; $display("FAIL b2b_alu1: got %b want 000", {st1, fi1, fe1}); end
    tick();
    set_instr(1, 4, 1, 3, 1, 5, 1, 0, 0, 0, 0, 0);       // sub x5,x4,x3
    @(negedge clk);
    n_cmp++; if ({st1, fi1, fe1} !== 3'b000) begin
      n_fail++; $display("FAIL b2b_alu2: got %b want 000", {st1, fi1, fe1}); end
    tick();
    set_instr(1, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0);       // jal x1
    @(negedge clk);
    n_cmp++; if ({st1, fi1, fe1} !== 3'b010 || pend1 !== 32'h0000_0020) begin
      n_fail++; $display("FAIL b2b_jal: got %b pend=%h want 010/00000020", {st1, fi1, fe1}, pend1); end
    tick();
    idle();
  endtask

  task automatic test_saturation();
    do_reset();
    exp_sc = 0;
    for (int i = 0; i < 20; i++) begin
      set_instr(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0);     // lw x5
      tick();
      set_instr(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0);     // add x6,x5
      @(negedge clk);
      n_cmp++; if (fes !== 1'b1) begin
        n_fail++; $display("FAIL sat_stall%0d: got %b want 1", i, fes); end
      tick();
      exp_sc = (exp_sc == 15) ? 15 : exp_sc + 1;
      @(negedge clk);
      n_cmp++; if (scs !== 4'(exp_sc)) begin
        n_fail++; $display("FAIL sat_count%0d: got %0d want %0d", i, scs, exp_sc); end
      tick();
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_branch();
    test_jalr_freeze();
    test_x0_waw();
    test_back_to_back();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
